// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings, command type and helpers for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    localparam int DEFAULT_RAM_SIZE = 256;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACCESS = ST_ACCESS,
        S_RESP   = ST_RESP
    } state_e;

    typedef struct packed {
        logic        owner;
        logic        wr;
        logic        oor;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Byte address lies beyond the last word of a memory of the given depth.
    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned words);
        logic [31:0] limit;
        limit = words << 2;
        return addr >= limit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_pick
// Description : Combinational two-way picker with fixed/round-robin and lock.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    input  logic prio_m0,
    input  logic lock1,
    output logic grant,
    output logic winner
);

    always_comb begin
        grant  = req0 | req1;
        winner = OWN_M0;
        // A locked burst only continues if M1 already owns the memory.
        if (req1 && lock1 && (last_owner == OWN_M1)) begin
            winner = OWN_M1;
        end else if (req0 && req1) begin
            winner = prio_m0 ? OWN_M0 : ~last_owner;
        end else if (req1) begin
            winner = OWN_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master req/ack arbiter in front of a single-port data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int RAM_SIZE = DEFAULT_RAM_SIZE,
    parameter int M0_PRIO  = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    state_e      r_state;
    state_e      w_state_nxt;
    cmd_t        r_cmd;
    logic        r_last_owner;

    logic        w_grant;
    logic        w_winner;
    logic        w_sel_wr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_resp_data;

    dmem_rr_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_owner (r_last_owner),
        .prio_m0    (M0_PRIO != 0),
        .lock1      (m1_lock),
        .grant      (w_grant),
        .winner     (w_winner)
    );

    assign w_sel_wr    = (w_winner == OWN_M1) ? m1_wr    : m0_wr;
    assign w_sel_addr  = (w_winner == OWN_M1) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_winner == OWN_M1) ? m1_wdata : m0_wdata;
    assign w_resp_data = (r_cmd.wr || r_cmd.oor) ? 32'd0 : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory strobes decode straight from the state register so that an
    // asynchronous reset removes a pending write in the same instant.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                busy        = 1'b1;
                mem_rd      = !r_cmd.wr && !r_cmd.oor;
                mem_wr      =  r_cmd.wr && !r_cmd.oor;
                mem_addr    = r_cmd.addr;
                mem_wdata   = r_cmd.wdata;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd        <= '0;
            r_last_owner <= OWN_M1;
        end else if ((r_state == S_IDLE) && w_grant) begin
            r_cmd.owner  <= w_winner;
            r_cmd.wr     <= w_sel_wr;
            r_cmd.addr   <= w_sel_addr;
            r_cmd.wdata  <= w_sel_wdata;
            r_cmd.oor    <= addr_oor(w_sel_addr, RAM_SIZE);
            r_last_owner <= w_winner;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'd0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'd0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            if (r_state == S_ACCESS) begin
                if (r_cmd.owner == OWN_M0) begin
                    m0_ack   <= 1'b1;
                    m0_err   <= r_cmd.oor;
                    m0_rdata <= w_resp_data;
                end else begin
                    m1_ack   <= 1'b1;
                    m1_err   <= r_cmd.oor;
                    m1_rdata <= w_resp_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter, fixed-priority and RR builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        m0_req, m0_wr, m1_req, m1_wr, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_mem_rd, a_mem_wr, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_mem_rd, b_mem_wr, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;

    logic        m0_ack, m0_err, m1_ack, m1_err, mem_rd, mem_wr, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [0:255];
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic        qo [$];

    assign m0_ack    = sel ? b_m0_ack    : a_m0_ack;
    assign m0_err    = sel ? b_m0_err    : a_m0_err;
    assign m0_rdata  = sel ? b_m0_rdata  : a_m0_rdata;
    assign m1_ack    = sel ? b_m1_ack    : a_m1_ack;
    assign m1_err    = sel ? b_m1_err    : a_m1_err;
    assign m1_rdata  = sel ? b_m1_rdata  : a_m1_rdata;
    assign mem_rd    = sel ? b_mem_rd    : a_mem_rd;
    assign mem_wr    = sel ? b_mem_wr    : a_mem_wr;
    assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
    assign busy      = sel ? b_busy      : a_busy;
    assign mem_rdata = ram[mem_addr[9:2]];

    dmem_arbiter #(.RAM_SIZE(256), .M0_PRIO(1)) u_dut_prio (
        .clk(clk), .reset(reset),
        .m0_req(m0_req & ~sel), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
        .m1_req(m1_req & ~sel), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock & ~sel),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .busy(a_busy)
    );

    dmem_arbiter #(.RAM_SIZE(256), .M0_PRIO(0)) u_dut_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req & sel), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(m1_req & sel), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock & sel),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .busy(b_busy)
    );

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | 32'(i);
        ram[4] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_addr[9:2]] <= mem_wdata;
            wr_pulses          <= wr_pulses + 1;
        end
        if (mem_rd) rd_pulses <= rd_pulses + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response for whichever master is acked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_ack && m1_ack) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dual_ack: got both acks expected one");
            end
            if ((m0_ack || m1_ack) && (qo.size() > 0))
                chk("grant_order", {31'd0, m1_ack}, {31'd0, qo.pop_front()});
            if (m0_ack) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL m0_unexpected_ack: got ack expected none");
                end else begin
                    e = q0.pop_front();
                    chk("m0_rdata", m0_rdata, e.rdata);
                    chk("m0_err", {31'd0, m0_err}, {31'd0, e.err});
                end
            end
            if (m1_ack) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL m1_unexpected_ack: got ack expected none");
                end else begin
                    e = q1.pop_front();
                    chk("m1_rdata", m1_rdata, e.rdata);
                    chk("m1_err", {31'd0, m1_err}, {31'd0, e.err});
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge inside the ack cycle.
    task automatic issue(input logic m, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input logic last);
        exp_t e;
        logic seen;
        e.rdata = exp_rd;
        e.err   = exp_err;
        seen    = 1'b0;
        if (m) begin
            q1.push_back(e);
            m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            q0.push_back(e);
            m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = m ? m1_ack : m0_ack;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout_m%0d: got no ack expected ack", m);
        end
        if (last) begin
            if (m) m1_req = 1'b0;
            else   m0_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r0;
        reset = 1'b0; sel = 1'b0;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic M0 read with latency checks
        q0.push_back('{32'hDEAD_BEEF, 1'b0});
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
        @(negedge clk);
        chk("t1_mem_rd_access", {31'd0, mem_rd}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_no_early_ack", {31'd0, m0_ack}, 32'd0);
        @(negedge clk);
        chk("t1_ack_latency", {31'd0, m0_ack}, 32'd1);
        chk("t1_mem_rd_single", {31'd0, mem_rd}, 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        chk("t1_ack_single", {31'd0, m0_ack}, 32'd0);
        chk("t1_back_idle", {31'd0, busy}, 32'd0);

        // M1 write then read of the top word
        w0 = wr_pulses;
        issue(1'b1, 1'b1, 32'h3FC, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        chk("t2_one_wr_pulse", 32'(wr_pulses - w0), 32'd1);
        issue(1'b1, 1'b0, 32'h3FC, 32'd0, 32'h1234_5678, 1'b0, 1'b1);
        chk("t2_ram_word", ram[255], 32'h1234_5678);

        // Out-of-range read and write
        w0 = wr_pulses; r0 = rd_pulses;
        issue(1'b0, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1, 1'b1);
        issue(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 32'd0, 1'b1, 1'b1);
        chk("t3_no_rd_strobe", 32'(rd_pulses - r0), 32'd0);
        chk("t3_no_wr_strobe", 32'(wr_pulses - w0), 32'd0);

        // Fixed priority: M0 keeps winning while it keeps requesting
        qo.push_back(1'b0); qo.push_back(1'b0); qo.push_back(1'b0); qo.push_back(1'b1);
        fork
            begin
                issue(1'b0, 1'b0, 32'h40, 32'd0, 32'hA500_0010, 1'b0, 1'b0);
                issue(1'b0, 1'b0, 32'h44, 32'd0, 32'hA500_0011, 1'b0, 1'b0);
                issue(1'b0, 1'b0, 32'h48, 32'd0, 32'hA500_0012, 1'b0, 1'b1);
            end
            issue(1'b1, 1'b0, 32'h4C, 32'd0, 32'hA500_0013, 1'b0, 1'b1);
        join

        // Locked M1 burst holds off M0
        qo.push_back(1'b1); qo.push_back(1'b1); qo.push_back(1'b1); qo.push_back(1'b1);
        qo.push_back(1'b0);
        fork
            begin
                m1_lock = 1'b1;
                for (int i = 0; i < 4; i++)
                    issue(1'b1, 1'b1, 32'h80 + 32'(4 * i), 32'hC0DE_0000 + 32'(i),
                          32'd0, 1'b0, i == 3);
                m1_lock = 1'b0;
            end
            begin
                @(negedge clk);
                issue(1'b0, 1'b0, 32'h90, 32'd0, 32'hA500_0024, 1'b0, 1'b1);
            end
        join
        chk("t5_burst_w0", ram[32], 32'hC0DE_0000);
        chk("t5_burst_w3", ram[35], 32'hC0DE_0003);

        // Round-robin build: grants alternate, first conflict to M0
        @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        qo.push_back(1'b0); qo.push_back(1'b1); qo.push_back(1'b0); qo.push_back(1'b1);
        fork
            begin
                issue(1'b0, 1'b0, 32'h40, 32'd0, 32'hA500_0010, 1'b0, 1'b0);
                issue(1'b0, 1'b0, 32'h44, 32'd0, 32'hA500_0011, 1'b0, 1'b1);
            end
            begin
                issue(1'b1, 1'b0, 32'h50, 32'd0, 32'hA500_0014, 1'b0, 1'b0);
                issue(1'b1, 1'b0, 32'h54, 32'd0, 32'hA500_0015, 1'b0, 1'b1);
            end
        join
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // Reset during the ACCESS cycle of an M1 write
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("t7_wr_in_access", {31'd0, mem_wr}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t7_wr_dropped", {31'd0, mem_wr}, 32'd0);
        chk("t7_busy_cleared", {31'd0, busy}, 32'd0);
        m1_req = 1'b0; m1_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_ram_kept", ram[8], 32'hA500_0008);
        chk("t7_rdata_cleared", m0_rdata, 32'd0);
        chk("t7_idle", {31'd0, busy}, 32'd0);

        issue(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("order_drained", 32'(qo.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
